shift_add_mult8: RTL and testbench

Sequential 8x8 unsigned multiplier producing a 16-bit product by shift-and-add over 8 iterations. It sits directly downstream of the 8-bit ripple-carry adder `Adder8` and is its consumer: each iteration feeds the partial-product high byte and the multiplicand into `Adder8`, then registers and shifts the `Sum`/`Cout` it returns. A start/done handshake lets a controller issue one multiplication at a time.

---
 rtl/shift_add_mult8_pkg.sv | 14 +
 rtl/shift_add_mult8_if.sv | 15 +
 rtl/shift_add_mult8_adder8.sv | 21 ++
 rtl/shift_add_mult8.sv | 77 +++++++
 tb/tb_shift_add_mult8.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/shift_add_mult8_pkg.sv
// Shared encodings for the shift-and-add multiplier: controller states and
// iteration count.
package shift_add_mult8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MUL_ITER = 8;
    localparam int CNT_W    = $clog2(MUL_ITER);

endpackage

// File: rtl/shift_add_mult8_if.sv
// Start/done handshake bundle between a controller (master) and the
// multiplier (slave).
interface shift_add_mult8_if;

    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);

endinterface

// File: rtl/shift_add_mult8_adder8.sv
// Adder8: fixed-width 8-bit ripple-carry adder, one full-adder stage per bit.
module shift_add_mult8_adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[8];

endmodule

// File: rtl/shift_add_mult8.sv
// Sequential 8x8 unsigned multiplier: one Adder8 add plus right shift per
// cycle over 8 iterations, with a start/busy/done handshake.
//
// state   | meaning
// IDLE    | waiting for start; operands captured on acceptance
// RUN     | one add-and-shift per edge, 8 edges
// DONE    | product valid, done high for this single cycle
module shift_add_mult8
    import shift_add_mult8_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    shift_add_mult8_if.slave  bus
);

    state_t             state;
    logic [7:0]         mcand;
    // {acc, mplr}; the carry bit of the 17-bit view is always zero after the
    // shift, so it is not stored.
    logic [15:0]        p;
    logic [CNT_W-1:0]   cnt;
    logic [15:0]        product_r;

    logic [7:0]         addend;
    logic [7:0]         sum;
    logic               cout;
    logic [15:0]        p_next;

    assign addend = p[0] ? mcand : 8'h00;

    shift_add_mult8_adder8 u_adder8 (
        .a    (p[15:8]),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Cout lands in bit 15 so no carry is lost.
    assign p_next = {cout, sum, p[7:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mcand     <= '0;
            p         <= '0;
            cnt       <= '0;
            product_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        mcand <= bus.a;
                        p     <= {8'h00, bus.b};
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    p   <= p_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(MUL_ITER - 1)) begin
                        product_r <= p_next;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = (state == ST_RUN);
    assign bus.done    = (state == ST_DONE);
    assign bus.product = product_r;

endmodule

// File: tb/tb_shift_add_mult8.sv
// Directed bench for shift_add_mult8: expected products are queued when an
// operation is driven and compared when done pulses.
module tb_shift_add_mult8;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;
    bit   both_high;
    logic [15:0] sb[$];

    shift_add_mult8_if bus ();

    shift_add_mult8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.busy && bus.done) both_high = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Counts rising edges until done is seen at the following falling edge.
    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        repeat (budget) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (bus.done) return;
        end
        cycles = -1;
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
    endtask

    task automatic drive_start(input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        sb.push_back(16'(x) * 16'(y));
    endtask

    task automatic finish_op(input string tag, input int exp_lat);
        int          lat;
        logic [15:0] exp;
        wait_done(30, lat);
        chk({tag, "_latency"}, lat, exp_lat);
        exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
        if (lat >= 0) begin
            chk({tag, "_product"}, {16'h0, bus.product}, {16'h0, exp});
            chk({tag, "_busy_at_done"}, {31'h0, bus.busy}, 32'h0);
        end
    endtask

    task automatic simple_op(input string tag, input logic [7:0] x, input logic [7:0] y);
        drive_start(x, y);
        @(posedge clk);
        #1 bus.start = 1'b0;
        finish_op(tag, 8);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, {31'h0, bus.done}, 32'h0);
    endtask

    initial begin
        int n_d;
        int lat;
        n_total   = 0;
        n_pass    = 0;
        both_high = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_done", {31'h0, bus.done}, 32'h0);
        chk("rst_product", {16'h0, bus.product}, 32'h0);
        rst = 1'b0;

        // Latency counted from the edge that accepts start (drive_start + 1 edge).
        drive_start(8'd13, 8'd11);
        finish_op("basic_13x11", 9);
        bus.start = 1'b0;
        @(negedge clk);
        chk("basic_done_one_cycle", {31'h0, bus.done}, 32'h0);

        simple_op("zero_x_a5", 8'h00, 8'hA5);
        simple_op("max_ff_ff", 8'hFF, 8'hFF);

        // start held and operands changed while RUN
        drive_start(8'd3, 8'd5);
        @(posedge clk);
        @(negedge clk);
        bus.a = 8'hFF;
        bus.b = 8'hFF;
        finish_op("busy_start", 8);
        bus.start = 1'b0;
        count_dones(12, n_d);
        chk("busy_start_single_done", n_d, 0);

        // reset during RUN, sampled at E4
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd7;
        bus.b     = 8'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_product", {16'h0, bus.product}, 32'h0);
        chk("abort_busy", {31'h0, bus.busy}, 32'h0);
        count_dones(12, n_d);
        chk("abort_no_done", n_d, 0);
        simple_op("after_abort_2x80", 8'd2, 8'h80);

        // back-to-back with start held continuously
        drive_start(8'd7, 8'd9);
        @(posedge clk);
        @(negedge clk);
        bus.a = 8'h80;
        bus.b = 8'h02;
        sb.push_back(16'h0100);
        finish_op("b2b_first", 8);
        repeat (5) @(negedge clk);
        chk("b2b_hold_product", {16'h0, bus.product}, 32'h003F);
        wait_done(30, lat);
        chk("b2b_spacing", (lat < 0) ? -1 : lat + 5, 10);
        bus.start = 1'b0;
        if (lat >= 0)
            chk("b2b_second_product", {16'h0, bus.product}, 32'h0100);
        void'(sb.pop_front());

        chk("busy_done_exclusive", {31'h0, both_high}, 32'h0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
